// File: rtl/regbank_seq.sv
// ---------------------------------------------------------------------------
// regbank_seq
//
// Sequencer that runs one register-bank operation at a time against an
// external single-port register bank. It reads operands, optionally adds
// them, and writes a result back.
// Ops: READ (00), WRITE (01), MOVE (10), ADD (11).
//
// State path per op (one cycle per state, all outputs registered):
//   READ  : IDLE -> RA -> RB -> DONE
//   WRITE : IDLE -> WB -> DONE
//   MOVE  : IDLE -> RA -> RB -> WB -> DONE
//   ADD   : IDLE -> RA -> RB -> CB -> WB -> DONE
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   start      in   request strobe, sampled only while ready=1
//   op         in   operation code
//   rd/rs/rt   in   destination / source A / source B register addresses
//   imm        in   write data for WRITE
//   ready      out  high only in IDLE
//   done       out  one-cycle completion pulse
//   result     out  operation result, valid while done=1, else 0
//   carry      out  ADD carry-out, valid while done=1, else 0
//   PA         out  bank address (0 when no strobe)
//   rdr/wrr    out  bank read / write strobes
//   wPA        out  bank write data (0 when no strobe)
//   bank_out   in   bank read data, valid the cycle after rdr=1
//
// Build option
//   REGBANK_SEQ_ZERO_R0_EN : register 0 is hard-zero. Reads of address 0
//   capture 0, and writes to address 0 keep wrr low. Latency is unchanged.
// ---------------------------------------------------------------------------
module regbank_seq #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic [DW-1:0] imm,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic [AW-1:0] PA,
    output logic          rdr,
    output logic          wrr,
    output logic [DW-1:0] wPA,
    input  logic [DW-1:0] bank_out
);

`ifdef REGBANK_SEQ_ZERO_R0_EN
    localparam bit ZeroR0 = 1'b1;
`else
    localparam bit ZeroR0 = 1'b0;
`endif

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RA, S_RB, S_CB, S_WB, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
    logic          ready_q, ready_d, done_q, done_d, carry_q, carry_d;
    logic          rdr_q, rdr_d, wrr_q, wrr_d;
    logic [DW-1:0] result_q, result_d, wpa_q, wpa_d;
    logic [AW-1:0] pa_q, pa_d;
    logic [DW:0]   sum_q;      // opA + opB from captured operands
    logic [DW:0]   sum_cb;     // opA + operand being captured in CB

    // Bank read data as seen by the sequencer (hard-zero r0 when enabled).
    function automatic logic [DW-1:0] capture(input logic [AW-1:0] addr,
                                              input logic [DW-1:0] data);
        return (ZeroR0 && (addr == '0)) ? '0 : data;
    endfunction

    // Whether a write to this address should reach the bank.
    function automatic logic wr_ok(input logic [AW-1:0] addr);
        return !(ZeroR0 && (addr == '0));
    endfunction

    assign sum_q  = {1'b0, opa_q} + {1'b0, opb_q};
    assign sum_cb = {1'b0, opa_q} + {1'b0, capture(rt_q, bank_out)};

    // Outputs are computed for the state being entered, so every output
    // is a flop and reflects the current state during its cycle.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        imm_d    = imm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        result_d = '0;
        carry_d  = 1'b0;
        pa_d     = '0;
        rdr_d    = 1'b0;
        wrr_d    = 1'b0;
        wpa_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    ready_d = 1'b0;
                    op_d    = op;
                    rd_d    = rd;
                    rs_d    = rs;
                    rt_d    = rt;
                    imm_d   = imm;
                    if (op == OP_WRITE) begin
                        state_d = S_WB;
                        if (wr_ok(rd)) begin
                            pa_d  = rd;
                            wrr_d = 1'b1;
                            wpa_d = imm;
                        end
                    end else begin
                        state_d = S_RA;
                        pa_d    = rs;
                        rdr_d   = 1'b1;
                    end
                end
            end
            S_RA: begin
                state_d = S_RB;
                if (op_q == OP_ADD) begin
                    pa_d  = rt_q;
                    rdr_d = 1'b1;
                end
            end
            S_RB: begin
                opa_d = capture(rs_q, bank_out);
                if (op_q == OP_ADD) begin
                    state_d = S_CB;
                end else if (op_q == OP_MOVE) begin
                    state_d = S_WB;
                    if (wr_ok(rd_q)) begin
                        pa_d  = rd_q;
                        wrr_d = 1'b1;
                        wpa_d = opa_d;
                    end
                end else begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = opa_d;
                end
            end
            S_CB: begin
                opb_d   = capture(rt_q, bank_out);
                state_d = S_WB;
                if (wr_ok(rd_q)) begin
                    pa_d  = rd_q;
                    wrr_d = 1'b1;
                    wpa_d = sum_cb[DW-1:0];
                end
            end
            S_WB: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                unique case (op_q)
                    OP_WRITE: result_d = imm_q;
                    OP_ADD: begin
                        result_d = sum_q[DW-1:0];
                        carry_d  = sum_q[DW];
                    end
                    OP_MOVE, OP_READ: result_d = opa_q;
                    default: result_d = opa_q;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Operation fields are plain data holders; they are only consulted
    // after being loaded on an accepted start.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        rd_q  <= rd_d;
        rs_q  <= rs_d;
        rt_q  <= rt_d;
        imm_q <= imm_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            pa_q     <= '0;
            rdr_q    <= 1'b0;
            wrr_q    <= 1'b0;
            wpa_q    <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            pa_q     <= pa_d;
            rdr_q    <= rdr_d;
            wrr_q    <= wrr_d;
            wpa_q    <= wpa_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign PA     = pa_q;
    assign rdr    = rdr_q;
    assign wrr    = wrr_q;
    assign wPA    = wpa_q;

endmodule

// File: tb/tb_regbank_seq.sv
// ---------------------------------------------------------------------------
// tb_regbank_seq
//
// Directed testbench for regbank_seq. The bench drives bank_out by hand in
// the cycles where the sequencer samples it. Expected values are
// hand-computed constants. Cycle k means the k-th clock period after the
// edge that accepted start. Outputs are sampled 1 time unit after each
// rising edge. Expectations for register 0 follow REGBANK_SEQ_ZERO_R0_EN.
// ---------------------------------------------------------------------------
module tb_regbank_seq;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] rd, rs, rt;
    logic [DW-1:0] imm;
    logic          ready, done, carry, rdr, wrr;
    logic [DW-1:0] result, wPA, bank_out;
    logic [AW-1:0] PA;

    int errors = 0;
    int checks = 0;
    int dones;

    always #5 clk = ~clk;

    regbank_seq #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .ready(ready), .done(done), .result(result), .carry(carry),
        .PA(PA), .rdr(rdr), .wrr(wrr), .wPA(wPA), .bank_out(bank_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge; returns in cycle 1.
    task automatic issue(input logic [1:0] o, input logic [AW-1:0] d,
                         input logic [AW-1:0] s, input logic [AW-1:0] t,
                         input logic [DW-1:0] im);
        op = o; rd = d; rs = s; rt = t; imm = im;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b0; op = 2'b00; rd = '0; rs = '0; rt = '0; imm = '0;
        bank_out = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_ready",  32'(ready),  1);
        chk("rst_done",   32'(done),   0);
        chk("rst_result", 32'(result), 0);
        chk("rst_carry",  32'(carry),  0);
        chk("rst_PA",     32'(PA),     0);
        chk("rst_rdr",    32'(rdr),    0);
        chk("rst_wrr",    32'(wrr),    0);
        chk("rst_wPA",    32'(wPA),    0);
        #10 rst = 1'b1;
        step();
        chk("idle_ready", 32'(ready), 1);

        // WRITE rd=1 imm=0x0404: WB in cycle 1, done in cycle 2
        issue(2'b01, 3'd1, 3'd0, 3'd0, 16'h0404);
        chk("wr_c1_wrr",   32'(wrr),   1);
        chk("wr_c1_rdr",   32'(rdr),   0);
        chk("wr_c1_PA",    32'(PA),    1);
        chk("wr_c1_wPA",   32'(wPA),   32'h0404);
        chk("wr_c1_ready", 32'(ready), 0);
        chk("wr_c1_done",  32'(done),  0);
        step();
        chk("wr_c2_done",   32'(done),   1);
        chk("wr_c2_result", 32'(result), 32'h0404);
        chk("wr_c2_wrr",    32'(wrr),    0);
        chk("wr_c2_PA",     32'(PA),     0);
        step();
        chk("wr_c3_ready",  32'(ready),  1);
        chk("wr_c3_result", 32'(result), 0);

        // READ rs=1, bank returns 0x0404: done in cycle 3
        bank_out = 16'h0404;
        issue(2'b00, 3'd0, 3'd1, 3'd0, 16'h0000);
        chk("rd_c1_rdr", 32'(rdr), 1);
        chk("rd_c1_PA",  32'(PA),  1);
        step();
        chk("rd_c2_rdr",  32'(rdr),  0);
        chk("rd_c2_PA",   32'(PA),   0);
        chk("rd_c2_done", 32'(done), 0);
        step();
        chk("rd_c3_done",   32'(done),   1);
        chk("rd_c3_result", 32'(result), 32'h0404);
        chk("rd_c3_carry",  32'(carry),  0);
        step();
        chk("rd_c4_ready", 32'(ready), 1);

        // ADD rs=2 (0xFFFF) + rt=3 (0x0002) -> rd=4: 0x0001 with carry
        bank_out = 16'hFFFF;
        issue(2'b11, 3'd4, 3'd2, 3'd3, 16'h0000);
        chk("add_c1_rdr", 32'(rdr), 1);
        chk("add_c1_PA",  32'(PA),  2);
        step();
        chk("add_c2_rdr", 32'(rdr), 1);
        chk("add_c2_PA",  32'(PA),  3);
        step();
        bank_out = 16'h0002;
        chk("add_c3_rdr", 32'(rdr), 0);
        chk("add_c3_wrr", 32'(wrr), 0);
        step();
        chk("add_c4_wrr", 32'(wrr), 1);
        chk("add_c4_PA",  32'(PA),  4);
        chk("add_c4_wPA", 32'(wPA), 32'h0001);
        chk("add_c4_done", 32'(done), 0);
        step();
        chk("add_c5_done",   32'(done),   1);
        chk("add_c5_result", 32'(result), 32'h0001);
        chk("add_c5_carry",  32'(carry),  1);
        step();
        chk("add_c6_carry", 32'(carry), 0);
        chk("add_c6_ready", 32'(ready), 1);

        // MOVE rs=5 -> rd=6 with start held high through the whole op
        // and the request fields changed underneath it.
        bank_out = 16'hABCD;
        op = 2'b10; rd = 3'd6; rs = 3'd5; rt = 3'd0; imm = 16'h0000;
        start = 1'b1;
        dones = 0;
        step();
        op = 2'b01; rd = 3'd1; rs = 3'd7; imm = 16'h9999;
        dones += int'(done);
        chk("mv_c1_ready", 32'(ready), 0);
        chk("mv_c1_PA",    32'(PA),    5);
        step();
        dones += int'(done);
        chk("mv_c2_ready", 32'(ready), 0);
        step();
        dones += int'(done);
        chk("mv_c3_ready", 32'(ready), 0);
        chk("mv_c3_wrr",   32'(wrr),   1);
        chk("mv_c3_PA",    32'(PA),    6);
        chk("mv_c3_wPA",   32'(wPA),   32'hABCD);
        step();
        dones += int'(done);
        chk("mv_c4_ready",  32'(ready),  0);
        chk("mv_c4_result", 32'(result), 32'hABCD);
        step();
        start = 1'b0;
        dones += int'(done);
        chk("mv_c5_ready", 32'(ready), 1);
        step();
        dones += int'(done);
        chk("mv_c6_wrr",   32'(wrr),   0);
        chk("mv_c6_rdr",   32'(rdr),   0);
        chk("mv_done_count", 32'(dones), 1);

        // Reset asserted mid-cycle during WB of a WRITE
        issue(2'b01, 3'd7, 3'd0, 3'd0, 16'h5555);
        chk("rs_c1_wrr", 32'(wrr), 1);
        #3 rst = 1'b0;
        #1;
        chk("rs_wrr",   32'(wrr),   0);
        chk("rs_ready", 32'(ready), 1);
        chk("rs_PA",    32'(PA),    0);
        chk("rs_wPA",   32'(wPA),   0);
        chk("rs_done",  32'(done),  0);
        #3 rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            dones += int'(done) + int'(wrr) + int'(rdr);
        end
        chk("rs_no_activity", 32'(dones), 0);
        chk("rs_idle_ready",  32'(ready), 1);
        issue(2'b01, 3'd2, 3'd0, 3'd0, 16'h0BB0);
        chk("rs_wr_wrr", 32'(wrr), 1);
        chk("rs_wr_PA",  32'(PA),  2);
        chk("rs_wr_wPA", 32'(wPA), 32'h0BB0);
        step();
        chk("rs_wr_done",   32'(done),   1);
        chk("rs_wr_result", 32'(result), 32'h0BB0);
        step();

        // Register 0 behaviour
        issue(2'b01, 3'd0, 3'd0, 3'd0, 16'h1234);
`ifdef REGBANK_SEQ_ZERO_R0_EN
        chk("r0_wr_wrr", 32'(wrr), 0);
        chk("r0_wr_wPA", 32'(wPA), 0);
`else
        chk("r0_wr_wrr", 32'(wrr), 1);
        chk("r0_wr_wPA", 32'(wPA), 32'h1234);
`endif
        chk("r0_wr_PA", 32'(PA), 0);
        step();
        chk("r0_wr_done",   32'(done),   1);
        chk("r0_wr_result", 32'(result), 32'h1234);
        step();
        bank_out = 16'hBEEF;
        issue(2'b00, 3'd0, 3'd0, 3'd0, 16'h0000);
        step();
        step();
        chk("r0_rd_done", 32'(done), 1);
`ifdef REGBANK_SEQ_ZERO_R0_EN
        chk("r0_rd_result", 32'(result), 0);
`else
        chk("r0_rd_result", 32'(result), 32'hBEEF);
`endif
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
